// File: rtl/fft2_pkg.sv
// Shared defaults, address-width derivation and FSM state type
// for the FFT2 result collector.
package fft2_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FFT_SIZE_DEF   = 16;

  function automatic int addr_w_f(input int fft_size);
    return $clog2(fft_size * fft_size);
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

endpackage

// File: rtl/fft2_result_ram.sv
// Simple dual-port result store: one write port, one read port
// with a registered (1-cycle) read.
module fft2_result_ram #(
  parameter int WIDTH = 64,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft2_dout_collector.sv
// Collects one FFT2 frame of {RE,IM} words in any address order,
// then drains it in ascending address order on a valid/ready stream.
module fft2_dout_collector
  import fft2_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int FFT_SIZE   = FFT_SIZE_DEF,
  localparam int ADDR_W     = addr_w_f(FFT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     data_o_addr_o,
  input  logic [DATA_WIDTH-1:0] dataRE_o,
  input  logic [DATA_WIDTH-1:0] dataIM_o,
  input  logic                  data_wr_o,
  output logic                  data_wr_i,
  output logic                  frame_done_o,
  output logic                  dup_err_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ADDR_W-1:0]     m_addr_o,
  output logic [DATA_WIDTH-1:0] m_re_o,
  output logic [DATA_WIDTH-1:0] m_im_o,
  output logic                  m_last_o
);

  localparam int              DEPTH  = FFT_SIZE * FFT_SIZE;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              issued_q, issued_d;
  logic              mvalid_q, mvalid_d;
  logic              mlast_q, mlast_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              fdone_q, fdone_d;
  logic              dup_q, dup_d;

  logic                    wr_acc;
  logic                    rd_en;
  logic                    hs;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign data_wr_i = !rst && (state_q == COLLECT);
  assign wr_acc    = data_wr_o && data_wr_i;
  assign hs        = mvalid_q && m_ready_i;
  // Fetch the next word when the output slot is empty or being taken.
  assign rd_en     = (state_q == DRAIN) && !issued_q
                     && (!mvalid_q || m_ready_i);

  fft2_result_ram #(
    .WIDTH (2*DATA_WIDTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (data_o_addr_o),
    .wr_data ({dataRE_o, dataIM_o}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    issued_d = issued_q;
    mvalid_d = mvalid_q;
    mlast_d  = mlast_q;
    maddr_d  = maddr_q;
    fdone_d  = 1'b0;
    dup_d    = dup_q;

    if (wr_acc) begin
      if (valid_q[data_o_addr_o]) begin
        dup_d = 1'b1;
      end else begin
        valid_d[data_o_addr_o] = 1'b1;
        count_d = count_q + 1'b1;
        if (count_d == DEPTH_C) begin
          state_d = DRAIN;
          fdone_d = 1'b1;
        end
      end
    end

    if (rd_en) begin
      mvalid_d = 1'b1;
      maddr_d  = rd_ptr_q;
      mlast_d  = (rd_ptr_q == LAST_C);
      rd_ptr_d = rd_ptr_q + 1'b1;
      issued_d = (rd_ptr_q == LAST_C);
    end else if (hs) begin
      mvalid_d = 1'b0;
      mlast_d  = 1'b0;
      if (mlast_q) begin
        state_d  = COLLECT;
        valid_d  = '0;
        count_d  = '0;
        rd_ptr_d = '0;
        issued_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      valid_q  <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      issued_q <= 1'b0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      maddr_q  <= '0;
      fdone_q  <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      issued_q <= issued_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      maddr_q  <= maddr_d;
      fdone_q  <= fdone_d;
      dup_q    <= dup_d;
    end
  end

  assign frame_done_o = fdone_q;
  assign dup_err_o    = dup_q;
  assign m_valid_o    = mvalid_q;
  assign m_last_o     = mlast_q;
  assign m_addr_o     = maddr_q;
  // RAM output is only meaningful while a word is presented.
  assign m_re_o = mvalid_q ? rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign m_im_o = mvalid_q ? rd_data[DATA_WIDTH-1:0] : '0;

endmodule

// File: doc/fft2_dout_collector.md
FFT2_DOUT_COLLECTOR -- requirements
Module: fft2_dout_collector

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high: the clock port is clk, the reset port is rst.
REQ-002 Parameter DATA_WIDTH, default 32: width of each real and imaginary sample, up to 32 bits.
REQ-003 Parameter FFT_SIZE, default 16: one frame is FFT_SIZE x FFT_SIZE words; ADDR_W = $clog2(FFT_SIZE*FFT_SIZE).
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 data_o_addr_o  in  ADDR_W  write address from the FFT2 producer.
REQ-007 dataRE_o  in  DATA_WIDTH  real part of the write data.
REQ-008 dataIM_o  in  DATA_WIDTH  imaginary part of the write data.
REQ-009 data_wr_o  in  1  producer write request.
REQ-010 data_wr_i  out  1  collector ready; a write is accepted in any cycle where data_wr_o=1 and data_wr_i=1.
REQ-011 frame_done_o  out  1  one-cycle pulse when a frame is complete.
REQ-012 dup_err_o  out  1  sticky flag: an address was written twice within one frame.
REQ-013 m_valid_o  out  1  drain-stream data valid.
REQ-014 m_ready_i  in  1  drain-stream consumer ready.
REQ-015 m_addr_o, m_re_o, m_im_o  out  ADDR_W / DATA_WIDTH / DATA_WIDTH  drained address and data.
REQ-016 m_last_o  out  1  high with the word at address FFT_SIZE*FFT_SIZE-1.

Function
REQ-017 The FSM SHALL have two states, COLLECT and DRAIN; data_wr_i SHALL be 1 only in COLLECT.
REQ-018 On an accepted write to an address whose valid bit is clear, the block SHALL store {RE, IM} at that address, set the valid bit and increment the word count.
REQ-019 On an accepted write to an address whose valid bit is already set, the block SHALL overwrite the data, set dup_err_o, and leave the word count unchanged.
REQ-020 The accepted write that brings the word count to FFT_SIZE*FFT_SIZE SHALL cause the following on the next cycle:
  - frame_done_o pulses for one cycle;
  - data_wr_i drops to 0;
  - the state changes to DRAIN.
REQ-021 data_wr_o asserted while data_wr_i=0 SHALL be ignored, with no write and no error.
REQ-022 DRAIN SHALL output addresses 0 to FFT_SIZE*FFT_SIZE-1 in ascending order.
  - The first m_valid_o is asserted exactly 2 cycles after the final accepted write.
REQ-023 While m_valid_o=1 and m_ready_i=0, m_valid_o and all m_* data outputs SHALL hold stable.
REQ-024 With m_ready_i held at 1, the block SHALL sustain one word per cycle, with no bubbles after the first word.
REQ-025 On the handshake of the word with m_last_o=1, the block SHALL:
  - clear all valid bits and the word count;
  - return to COLLECT, with data_wr_i=1 on the next cycle.
REQ-026 dup_err_o SHALL be cleared only by rst.
REQ-027 Write data SHALL be stored and drained bit-exact, with no arithmetic or width change.

Reset
REQ-028 While rst=1:
  - data_wr_i, frame_done_o, dup_err_o, m_valid_o and m_last_o are 0;
  - m_addr_o, m_re_o and m_im_o are 0;
  - state is COLLECT; word count and valid bitmap are cleared.
REQ-029 data_wr_i SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst during DRAIN SHALL abort the drain; RAM contents need not be cleared.

Structure
REQ-031 Package fft2_pkg SHALL hold the following; no other shared types are added:
  - DATA_WIDTH and FFT_SIZE defaults;
  - the ADDR_W derivation;
  - the COLLECT/DRAIN state enum.
REQ-032 The storage SHALL be a sub-module fft2_result_ram: simple dual-port, synchronous read with 1-cycle latency, and one write port.

Verification
REQ-033 Frame drain, FFT_SIZE=4: write addresses 0..15 in order with RE=addr, IM=~addr and m_ready_i=1 -> all of the following:
  - frame_done_o pulses once;
  - 16 words drain in order, with m_last_o only on address 15;
  - data_wr_i returns to 1 on the cycle after the last handshake.
REQ-034 Duplicate write: write address 3 twice (RE=5, then RE=9), then addresses 0..15 except 3 -> all of the following:
  - dup_err_o=1;
  - the frame completes after 16 unique addresses;
  - the drained word at address 3 has RE=9.
REQ-035 Backpressure: toggle m_ready_i randomly at a 50% rate during DRAIN -> outputs are stable while stalled, and every word is seen exactly once.
REQ-036 Writes while not ready: hold data_wr_o=1 with address 7, RE=0xDEAD during DRAIN -> the drained data is unchanged and dup_err_o stays 0.
REQ-037 Reset mid-drain: assert rst after 5 drained words -> all of the following:
  - all outputs are 0 during reset;
  - data_wr_i=1 on the first cycle after reset;
  - a new frame of 16 words collects and drains correctly.
